pipe_stall_ctrl: RTL and testbench

- Central stall controller for the 5-stage MIPS pipeline (PC/IF/ID/EX/MEM/WB).
- Merges three stall sources into the shared `StallBus` vector consumed by every stage register:
  - ID load-use hazard.
  - EX multi-cycle mult/div unit.
  - MEM data-SRAM wait.
- Sequences the mult/div handshake with a small FSM.
- Tells ID when to replay its captured instruction after a stall releases.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl_if.sv | 59 +++++
 rtl/pipe_stall_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stall_ctrl_if                                              |
// | Purpose  : Bundles the stall-controller hazard inputs and StallBus /       |
// |            status outputs into one interface.                              |
// | Ports    : ld_use_req, md_start, md_ready, mem_wait, flush  (to ctrl)      |
// |            stall[5:0], stall_cause[2:0], id_inst_replay, md_busy,          |
// |            md_timeout, perf_stall_cnt[CNT_W-1:0]            (from ctrl)    |
// | Modports : slave  - the stall controller                                   |
// |            master - the pipeline side (hazard sources and stage regs)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard sources
  logic             ld_use_req;
  logic             md_start;
  logic             md_ready;
  logic             mem_wait;
  logic             flush;

  // Stall bus and status
  logic [5:0]       stall;
  logic [2:0]       stall_cause;
  logic             id_inst_replay;
  logic             md_busy;
  logic             md_timeout;
  logic [CNT_W-1:0] perf_stall_cnt;

  modport slave (
    input  ld_use_req,
    input  md_start,
    input  md_ready,
    input  mem_wait,
    input  flush,
    output stall,
    output stall_cause,
    output id_inst_replay,
    output md_busy,
    output md_timeout,
    output perf_stall_cnt
  );

  modport master (
    output ld_use_req,
    output md_start,
    output md_ready,
    output mem_wait,
    output flush,
    input  stall,
    input  stall_cause,
    input  id_inst_replay,
    input  md_busy,
    input  md_timeout,
    input  perf_stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stall_ctrl                                                 |
// | Purpose  : Central stall controller for the 5-stage MIPS pipeline.         |
// |            Merges the load-use, mult/div and data-SRAM stall sources into  |
// |            the shared StallBus, sequences the mult/div handshake, flags    |
// |            ID instruction replay and counts stalled cycles.                |
// | Ports    : clk  - pipeline clock                                           |
// |            rst  - asynchronous reset, active low                           |
// |            bus  - pipe_stall_ctrl_if.slave                                 |
// |                   in : ld_use_req, md_start, md_ready, mem_wait, flush     |
// |                   out: stall[5:0] (bit0 PC .. bit5 WB, 1 = stop),          |
// |                        stall_cause[2:0] one-hot {mem, md, ld_use},         |
// |                        id_inst_replay, md_busy, md_timeout (sticky),       |
// |                        perf_stall_cnt[CNT_W-1:0] (saturating)              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipe_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_stall_ctrl_if.slave   bus
);

  // Width of the BUSY-cycle counter; it only ever has to reach MD_TIMEOUT-1.
  localparam int                MD_CW   = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MD_CW-1:0]  MD_LAST = MD_CW'(MD_TIMEOUT - 1);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_MD   = 6'b001111;
  localparam logic [5:0] STALL_LDU  = 6'b000111;

  localparam logic [2:0] CAUSE_MEM  = 3'b100;
  localparam logic [2:0] CAUSE_MD   = 3'b010;
  localparam logic [2:0] CAUSE_LDU  = 3'b001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_HOLD = 2'd2
  } md_state_e;

  md_state_e         md_state_q, md_state_d;
  logic [MD_CW-1:0]  md_cnt_q,   md_cnt_d;
  logic              md_timeout_q, md_timeout_d;
  logic              replay_q,   replay_d;
  logic [CNT_W-1:0]  perf_cnt_q, perf_cnt_d;

  logic              md_stall;
  logic [5:0]        stall_w;
  logic [2:0]        cause_w;

  // --------------------------------------------------------------------------
  // Mult/div stall request, derived from the FSM state and this cycle's inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    md_stall = 1'b0;
    unique case (md_state_q)
      // A new op stalls in its issue cycle unless it is being flushed.
      MD_IDLE: md_stall = bus.md_start && !bus.flush;
      // The stall releases in the md_ready cycle so EX captures the result.
      MD_BUSY: md_stall = !bus.md_ready;
      // The result is parked only while MEM blocks; when MEM frees, EX takes
      // the result in that same cycle, mirroring the md_ready release in BUSY.
      MD_HOLD: md_stall = bus.mem_wait;
      default: md_stall = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // StallBus priority merge: mem > md > ld_use. A lower-priority hazard that is
  // masked simply re-evaluates next cycle, because its source is still present.
  // While reset is asserted the bus is forced quiet.
  // --------------------------------------------------------------------------
  always_comb begin
    stall_w = 6'b000000;
    cause_w = 3'b000;
    if (!rst) begin
      stall_w = 6'b000000;
      cause_w = 3'b000;
    end else if (bus.mem_wait) begin
      stall_w = STALL_MEM;
      cause_w = CAUSE_MEM;
    end else if (md_stall) begin
      stall_w = STALL_MD;
      cause_w = CAUSE_MD;
    end else if (bus.ld_use_req) begin
      // ID holds while EX advances, so ID injects a bubble into EX.
      stall_w = STALL_LDU;
      cause_w = CAUSE_LDU;
    end
  end

  // --------------------------------------------------------------------------
  // Mult/div sequencer next state.
  // --------------------------------------------------------------------------
  always_comb begin
    md_state_d   = md_state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    unique case (md_state_q)
      MD_IDLE: begin
        if (bus.md_start && !bus.flush) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = '0;
        end
      end
      MD_BUSY: begin
        // md_start is deliberately ignored here: an op in flight cannot restart.
        if (bus.flush) begin
          md_state_d = MD_IDLE;
        end else if (bus.md_ready) begin
          md_state_d = bus.mem_wait ? MD_HOLD : MD_IDLE;
        end else if (md_cnt_q == MD_LAST) begin
          // Give up on a unit that never answers; the stall drops next cycle.
          md_timeout_d = 1'b1;
          md_state_d   = MD_IDLE;
        end else begin
          md_cnt_d = md_cnt_q + 1'b1;
        end
      end
      MD_HOLD: begin
        if (bus.flush || !bus.mem_wait) begin
          md_state_d = MD_IDLE;
        end
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Replay flag and saturating stall-cycle counter.
  // --------------------------------------------------------------------------
  always_comb begin
    // IF was held last cycle, so ID must reuse its buffered instruction; a
    // flush discards that instruction instead.
    replay_d = stall_w[1] && !bus.flush;

    perf_cnt_d = perf_cnt_q;
    if (stall_w[0] && (perf_cnt_q != {CNT_W{1'b1}})) begin
      perf_cnt_d = perf_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_state_q   <= MD_IDLE;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
      replay_q     <= 1'b0;
      perf_cnt_q   <= '0;
    end else begin
      md_state_q   <= md_state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
      replay_q     <= replay_d;
      perf_cnt_q   <= perf_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs.
  // --------------------------------------------------------------------------
  assign bus.stall          = stall_w;
  assign bus.stall_cause    = cause_w;
  assign bus.id_inst_replay = replay_q;
  assign bus.md_busy        = (md_state_q != MD_IDLE);
  assign bus.md_timeout     = md_timeout_q;
  assign bus.perf_stall_cnt = perf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_stall_ctrl                                              |
// | Purpose  : Directed self-checking bench for pipe_stall_ctrl, built with    |
// |            MD_TIMEOUT=8 and CNT_W=4 so timeout and saturation are short.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs for the new cycle are
  // driven right after this returns.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ld_use_req = 1'b0;
    bus.md_start   = 1'b0;
    bus.md_ready   = 1'b0;
    bus.mem_wait   = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if ({bus.stall, bus.stall_cause, bus.id_inst_replay, bus.md_busy, bus.md_timeout} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {bus.stall, bus.stall_cause, bus.id_inst_replay, bus.md_busy, bus.md_timeout});
    end
    cyc();
    rst = 1'b1;
    bus.md_start = 1'b1;
    sample();
    cyc();
    bus.md_start = 1'b0;
    cyc();
    // BUSY cycle 2: toggle everything, then pull reset between edges.
    bus.ld_use_req = 1'b1;
    bus.mem_wait   = 1'b1;
    bus.md_start   = 1'b1;
    bus.flush      = 1'b1;
    #1;
    checks++;
    if (bus.md_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got %b want 1", bus.md_busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.stall, bus.stall_cause, bus.id_inst_replay, bus.md_busy} !== 11'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got %b want 0",
               {bus.stall, bus.stall_cause, bus.id_inst_replay, bus.md_busy});
    end
    checks++;
    if (bus.perf_stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_perf got %0d want 0", bus.perf_stall_cnt);
    end
    clear_inputs();
    cyc();
    rst = 1'b1;
    sample();
    checks++;
    if ({bus.md_busy, bus.stall} !== 7'b0) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 0", {bus.md_busy, bus.stall});
    end
    cyc();
    bus.md_start = 1'b1;
    sample();
    checks++;
    if (bus.stall !== 6'b001111) begin
      errors++;
      $display("FAIL post_reset_md_issue got %b want 001111", bus.stall);
    end
    cyc();
    bus.md_start = 1'b0;
    sample();
    checks++;
    if (bus.md_busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_enter_busy got %b want 1", bus.md_busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_use();
    do_reset();
    bus.ld_use_req = 1'b1;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause, bus.id_inst_replay} !== {6'b000111, 3'b001, 1'b0}) begin
      errors++;
      $display("FAIL ldu_stall got %b want 0001110010", {bus.stall, bus.stall_cause, bus.id_inst_replay});
    end
    cyc();
    bus.ld_use_req = 1'b0;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause, bus.id_inst_replay} !== {6'b000000, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL ldu_release got %b want 0000000001", {bus.stall, bus.stall_cause, bus.id_inst_replay});
    end
    cyc();
    sample();
    checks++;
    if (bus.id_inst_replay !== 1'b0) begin
      errors++;
      $display("FAIL ldu_replay_clear got %b want 0", bus.id_inst_replay);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_md_nominal();
    do_reset();
    bus.md_start = 1'b1;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause, bus.md_busy} !== {6'b001111, 3'b010, 1'b0}) begin
      errors++;
      $display("FAIL md_c0 got %b want 0011110100", {bus.stall, bus.stall_cause, bus.md_busy});
    end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      bus.md_start = (c == 2);   // a repeated start while BUSY must be ignored
      sample();
      checks++;
      if ({bus.stall, bus.md_busy} !== {6'b001111, 1'b1}) begin
        errors++;
        $display("FAIL md_c%0d got %b want 0011111", c, {bus.stall, bus.md_busy});
      end
    end
    cyc();
    bus.md_start = 1'b0;
    bus.md_ready = 1'b1;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause, bus.md_busy} !== {6'b000000, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL md_c5 got %b want 0000000001", {bus.stall, bus.stall_cause, bus.md_busy});
    end
    cyc();
    bus.md_ready = 1'b0;
    sample();
    checks++;
    if ({bus.md_busy, bus.perf_stall_cnt} !== {1'b0, 4'd5}) begin
      errors++;
      $display("FAIL md_c6_busy_perf got %b want 00101", {bus.md_busy, bus.perf_stall_cnt});
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_md_mem();
    do_reset();
    bus.md_start = 1'b1;
    cyc();
    bus.md_start = 1'b0;
    cyc();
    cyc();
    bus.md_ready = 1'b1;
    bus.mem_wait = 1'b1;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause} !== {6'b011111, 3'b100}) begin
      errors++;
      $display("FAIL mdmem_c3 got %b want 011111100", {bus.stall, bus.stall_cause});
    end
    for (int c = 4; c <= 6; c++) begin
      cyc();
      bus.md_ready = 1'b0;
      sample();
      checks++;
      if ({bus.stall, bus.md_busy} !== {6'b011111, 1'b1}) begin
        errors++;
        $display("FAIL mdmem_hold_c%0d got %b want 0111111", c, {bus.stall, bus.md_busy});
      end
    end
    cyc();
    bus.mem_wait = 1'b0;
    sample();
    checks++;
    if ({bus.stall, bus.md_busy} !== {6'b000000, 1'b1}) begin
      errors++;
      $display("FAIL mdmem_c7 got %b want 0000001", {bus.stall, bus.md_busy});
    end
    cyc();
    sample();
    checks++;
    if ({bus.md_busy, bus.perf_stall_cnt} !== {1'b0, 4'd7}) begin
      errors++;
      $display("FAIL mdmem_c8_busy_perf got %b want 00111", {bus.md_busy, bus.perf_stall_cnt});
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_timeout();
    do_reset();
    bus.md_start = 1'b1;
    cyc();
    bus.md_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      sample();
      checks++;
      if ({bus.stall, bus.md_timeout} !== {6'b001111, 1'b0}) begin
        errors++;
        $display("FAIL to_busy_c%0d got %b want 0011110", c, {bus.stall, bus.md_timeout});
      end
      cyc();
    end
    sample();
    checks++;
    if ({bus.stall, bus.md_busy, bus.md_timeout} !== {6'b000000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL to_expire got %b want 00000001", {bus.stall, bus.md_busy, bus.md_timeout});
    end
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    cyc();
    sample();
    checks++;
    if (bus.md_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky got %b want 1", bus.md_timeout);
    end
    do_reset();
    sample();
    checks++;
    if (bus.md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_reset_clear got %b want 0", bus.md_timeout);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_flush();
    do_reset();
    bus.md_start = 1'b1;
    cyc();
    bus.md_start = 1'b0;
    cyc();
    bus.flush = 1'b1;
    sample();
    checks++;
    if (bus.stall !== 6'b001111) begin
      errors++;
      $display("FAIL fl_c2 got %b want 001111", bus.stall);
    end
    cyc();
    bus.flush = 1'b0;
    sample();
    checks++;
    if ({bus.stall, bus.md_busy, bus.id_inst_replay} !== 8'b0) begin
      errors++;
      $display("FAIL fl_c3 got %b want 0", {bus.stall, bus.md_busy, bus.id_inst_replay});
    end
    for (int c = 0; c < 10; c++) cyc();
    sample();
    checks++;
    if (bus.md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL fl_no_timeout got %b want 0", bus.md_timeout);
    end
    cyc();
    bus.md_start = 1'b1;
    bus.flush    = 1'b1;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause} !== 9'b0) begin
      errors++;
      $display("FAIL fl_start_and_flush got %b want 0", {bus.stall, bus.stall_cause});
    end
    cyc();
    clear_inputs();
    sample();
    checks++;
    if (bus.md_busy !== 1'b0) begin
      errors++;
      $display("FAIL fl_stay_idle got %b want 0", bus.md_busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mem_vs_ldu();
    do_reset();
    bus.mem_wait   = 1'b1;
    bus.ld_use_req = 1'b1;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause} !== {6'b011111, 3'b100}) begin
      errors++;
      $display("FAIL prio_mem got %b want 011111100", {bus.stall, bus.stall_cause});
    end
    cyc();
    bus.mem_wait = 1'b0;
    sample();
    checks++;
    if ({bus.stall, bus.stall_cause} !== {6'b000111, 3'b001}) begin
      errors++;
      $display("FAIL prio_ldu_after got %b want 000111001", {bus.stall, bus.stall_cause});
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_saturation();
    do_reset();
    bus.mem_wait = 1'b1;
    for (int c = 0; c < 10; c++) cyc();
    sample();
    checks++;
    if (bus.perf_stall_cnt !== 4'hA) begin
      errors++;
      $display("FAIL sat_mid got %h want a", bus.perf_stall_cnt);
    end
    for (int c = 10; c < 20; c++) cyc();
    bus.mem_wait = 1'b0;
    sample();
    checks++;
    if (bus.perf_stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold got %h want f", bus.perf_stall_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_md_nominal();
    test_md_mem();
    test_timeout();
    test_flush();
    test_mem_vs_ldu();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
